la_spregfile_port: RTL and testbench

//  Requester-side adapter that drives a la_spregfile instance from a valid/ready request stream.

---
 rtl/la_spregfile_port.sv | 150 +++++++++++++++
 tb/tb_la_spregfile_port.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_spregfile_port.sv
// Requester-side adapter between a valid/ready request stream and a la_spregfile macro.
// Optional power-up zeroing sweep is compiled in with LA_SPREGFILE_INIT_EN.
module la_spregfile_port #(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wmask,
  input  logic [DW-1:0] req_din,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [DW-1:0] mem_wmask,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a request transfers on a clock edge where req_valid & req_ready;
  // a response transfers on a clock edge where rsp_valid & rsp_ready.

  logic          run;
  logic          rd_pend;
  logic          rd_issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW:0]   credit;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [DW-1:0] fifo_mem [DEPTH];

`ifdef LA_SPREGFILE_INIT_EN
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [AW:0] sweep_cnt;
  logic [AW:0] sweep_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_next;
      sweep_cnt <= sweep_next;
    end
  end

  // The sweep is done once the counter carries into its MSB.
  always_comb begin
    state_next = state;
    sweep_next = sweep_cnt;
    if (state == ST_INIT) begin
      sweep_next = sweep_cnt + 1'b1;
      if (sweep_next[AW]) begin
        state_next = ST_RUN;
      end
    end
  end

  assign run  = (state == ST_RUN);
  assign busy = (state == ST_INIT);
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // Credits count both stored entries and the read whose data is still in the macro.
  always_comb begin
    credit    = {1'b0, count} + (CW+1)'(rd_pend);
    req_ready = run & ~reset & (credit < (CW+1)'(DEPTH));
    mem_ce    = req_valid & req_ready;
    mem_we    = req_we;
    mem_wmask = req_wmask;
    mem_addr  = req_addr;
    mem_din   = req_din;
`ifdef LA_SPREGFILE_INIT_EN
    if (busy && !reset) begin
      mem_ce    = 1'b1;
      mem_we    = 1'b1;
      mem_wmask = '1;
      mem_addr  = sweep_cnt[AW-1:0];
      mem_din   = '0;
    end
`endif
  end

  assign rd_issue  = req_valid & req_ready & ~req_we;
  assign push      = rd_pend;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = fifo_mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_issue;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_dout;
    end
  end

endmodule

// File: tb/tb_la_spregfile_port.sv
// Directed plus randomized bench for la_spregfile_port with a behavioural macro and reference model.
// Build with LA_SPREGFILE_INIT_EN to exercise the zeroing sweep (AW shrinks to 4).
module tb_la_spregfile_port;

  localparam int DW    = 32;
`ifdef LA_SPREGFILE_INIT_EN
  localparam int AW    = 4;
`else
  localparam int AW    = 10;
`endif
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wmask = '0;
  logic [DW-1:0] req_din = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          mem_ce;
  logic          mem_we;
  logic [DW-1:0] mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  la_spregfile_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wmask (req_wmask),
    .req_din   (req_din),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_wmask (mem_wmask),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural single-port macro: registered read data, bit-masked writes.
  logic [DW-1:0] mem_arr [2**AW];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) mem_arr[mem_addr] <= (mem_arr[mem_addr] & ~mem_wmask) | (mem_din & mem_wmask);
      else        mem_dout <= mem_arr[mem_addr];
    end
  end

  // Scoreboard: reference memory image plus expected response queue.
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  int n_tests = 0;
  int n_fail  = 0;
  int rsp_cnt = 0;
  logic rand_rdy = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
`ifdef LA_SPREGFILE_INIT_EN
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
`endif
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        n_tests++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL rsp_unexpected observed=%0h expected=none", rsp_data);
        end
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          n_tests++;
          assert (rsp_data === exp_v) else begin
            n_fail++;
            $error("FAIL rsp_data observed=%0h expected=%0h", rsp_data, exp_v);
          end
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_din & req_wmask);
        else        exp_q.push_back(ref_mem[req_addr]);
      end
    end
  end

  // Driver tasks
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] m,
                        input logic [DW-1:0] d);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wmask = m;
    req_din   = d;
    n = 0;
    while (!req_ready && n < 64) begin
      cyc();
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    cyc();
    req_valid = 1'b0;
  endtask

  logic [AW-1:0] rd_tab [32];

  task automatic burst(input int start, input int n, input int max_c, output int acc,
                       output int stalls);
    logic rd;
    acc    = 0;
    stalls = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int c = 0; c < max_c && acc < n; c++) begin
      req_addr = rd_tab[start + acc];
      rd = req_ready;
      if (!rd) stalls++;
      cyc();
      if (rd) acc++;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input int max_c);
    for (int c = 0; c < max_c && exp_q.size() != 0; c++) cyc();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 2**AW + 8 && busy; c++) cyc();
    chk("idle", busy, 0);
  endtask

  // Directed and randomized sequence
  int acc, stalls, r0, k;
  logic [DW-1:0] d;
  logic rd;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
`ifdef LA_SPREGFILE_INIT_EN
    chk("reset_busy", busy, 1);
`else
    chk("reset_busy", busy, 0);
`endif
    chk("reset_req_ready", req_ready, 0);
    req_valid = 1'b1;
    #1;
    chk("reset_mem_ce", mem_ce, 0);
    req_valid = 1'b0;
    reset = 1'b0;

`ifdef LA_SPREGFILE_INIT_EN
    for (int i = 0; i < 16; i++) begin
      chk("init_busy", busy, 1);
      chk("init_req_ready", req_ready, 0);
      chk("init_addr", mem_addr, i);
      chk("init_we", {mem_ce, mem_we}, 2'b11);
      chk("init_mask_din", {mem_wmask, mem_din}, {{DW{1'b1}}, {DW{1'b0}}});
      cyc();
    end
    chk("init_done_busy", busy, 0);
    chk("init_done_ready", req_ready, 1);
    do_req(1'b0, 4'd7, '0, '0);
    cyc();
    chk("init_rd7_valid", rsp_valid, 1);
    chk("init_rd7_data", rsp_data, 0);
`endif
    cyc();

    // Write then read: two-cycle read latency
    do_req(1'b1, 3, '1, 32'hA5A5A5A5);
    do_req(1'b0, 3, '1, '0);
    chk("t1_valid_n1", rsp_valid, 0);
    cyc();
    chk("t1_valid_n2", rsp_valid, 1);
    chk("t1_data", rsp_data, 32'hA5A5A5A5);
    cyc();

    // Bit-masked write
    do_req(1'b1, 5, '1, 32'hFFFFFFFF);
    do_req(1'b1, 5, 32'h0000FFFF, 32'h00000000);
    do_req(1'b0, 5, '0, '0);
    cyc();
    chk("t2_valid", rsp_valid, 1);
    chk("t2_data", rsp_data, 32'hFFFF0000);
    cyc();

    // Backpressure: credits cap outstanding reads at DEPTH
    for (int i = 0; i < 6; i++) begin
      do_req(1'b1, AW'(i), '1, DW'(i));
      rd_tab[i] = AW'(i);
    end
    rsp_ready = 1'b0;
    burst(0, 6, 8, acc, stalls);
    chk("t3_accepted", acc, 4);
    chk("t3_req_ready", req_ready, 0);
    chk("t3_rsp_valid", rsp_valid, 1);
    r0 = rsp_cnt;
    rsp_ready = 1'b1;
    burst(4, 2, 20, acc, stalls);
    chk("t3_accepted2", acc, 2);
    drain(20);
    chk("t3_rsp_count", rsp_cnt - r0, 6);

    // Full-rate random reads with the consumer always ready
    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, AW'(i), '1, $urandom);
      rd_tab[i] = AW'($urandom_range(0, 15));
    end
    drain(10);
    r0 = rsp_cnt;
    burst(0, 16, 40, acc, stalls);
    chk("t4_accepted", acc, 16);
    chk("t4_stalls", stalls, 0);
    chk("t4_rsp_mid", rsp_cnt - r0, 14);
    cyc();
    cyc();
    chk("t4_rsp_all", rsp_cnt - r0, 16);

    // Reset with a read in flight and two entries stored
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) rd_tab[i] = AW'(i);
    burst(0, 3, 10, acc, stalls);
    chk("t5_accepted", acc, 3);
    reset = 1'b1;
    #1;
    chk("t5_rsp_valid_async", rsp_valid, 0);
    chk("t5_req_ready", req_ready, 0);
    rsp_ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    wait_idle();
    r0 = rsp_cnt;
    repeat (4) cyc();
    chk("t5_stale", rsp_cnt - r0, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    d = $urandom;
    do_req(1'b1, 9, '1, d);
    do_req(1'b0, 9, '0, '0);
    cyc();
    chk("t5_new_data", rsp_data, d);
    cyc();

    // Random mix of masked writes and reads under random backpressure
    rand_rdy  = 1'b1;
    k         = 0;
    req_valid = 1'b1;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = AW'($urandom_range(0, 15));
    req_wmask = $urandom;
    req_din   = $urandom;
    for (int c = 0; c < 400 && k < 80; c++) begin
      rd = req_ready;
      cyc();
      if (rd) begin
        k++;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom_range(0, 15));
        req_wmask = $urandom;
        req_din   = $urandom;
      end
    end
    req_valid = 1'b0;
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    chk("t7_issued", k, 80);
    drain(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
